uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It is the next generation of the fixed 8-N-1 transmit path used by the RISC-V pipeline's UART peripheral. Data width, parity mode, stop-bit count, bit period and FIFO depth are all configurable. It also adds back-to-back framing, overflow detection and FIFO level reporting, which the fixed transmitter does not have.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2
DATA_BITS, 8, payload bits per frame; legal range 5..8
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2
FIFO_DEPTH, 8, number of FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous and active-high
wr_en  input  1  push wr_data into the FIFO on this clock edge
wr_data  input  DATA_BITS  byte/word to transmit
clr_overflow  input  1  clear the sticky overflow flag
tx  output  1  serial line; idles high
busy  output  1  a frame is in progress (state != IDLE)
full  output  1  FIFO full (count == FIFO_DEPTH)
empty  output  1  FIFO empty (count == 0)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries
overflow  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (asynchronous, immediate): tx=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0. Read/write pointers, baud counter, bit counter and shift register all clear; FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame at once: tx returns high asynchronously and FIFO contents are discarded.
- FIFO write: if wr_en=1 and full=0 at the edge, store the word at wr_ptr and increment wr_ptr (mod FIFO_DEPTH).
- Write while full: word dropped, overflow set to 1. Writes are rejected whenever the registered full is 1, even if a pop occurs on the same edge.
- overflow clears on clr_overflow=1. If clr_overflow and a rejected write coincide, set wins.
- Pop/write interaction: a pop and an accepted write on the same edge leave fifo_count unchanged.
- full, empty and fifo_count are registered and derived from the pointer state after each edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If empty=0 at an edge, pop the head word into the shift register, go to START and drive tx=0 from that edge.
- Write-to-line latency: a write accepted at edge E0 into an empty, idle block gives the tx falling edge at E1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift out LSB first, DATA_BITS bits, each held for CLKS_PER_BIT cycles. Then go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: even mode drives the XOR of all data bits; odd mode drives its inverse. Held for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP: if empty=0, pop and go directly to START with no idle cycle (back-to-back); otherwise go to IDLE.
- Frame length: CLKS_PER_BIT*(1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) cycles exactly.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Bit transitions occur only when the counter wraps.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is tracked separately so that full and empty are unambiguous.
- tx is driven from a register (glitch-free). busy is high from the START edge through the last STOP cycle.
- PARITY_MODE values 3 and above are treated as 0.

Test Plan:
- CLKS_PER_BIT=4, 8-N-1: write 0xA5 to an idle block. tx holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles); falling edge one edge after the write; busy high for exactly 40 cycles; empty=1 afterwards.
- PARITY_MODE=1, write 0x07: parity bit = 1. PARITY_MODE=2, write 0x07: parity bit = 0. Frame is 44 cycles with CLKS_PER_BIT=4.
- FIFO_DEPTH=4: write 6 words on consecutive edges (first popped one edge later). Result: fifo_count=4, full=1, overflow=1, 6th word never transmitted; after clr_overflow, overflow=0; the 5 accepted words transmit in order.
- Back-to-back 0x01, 0x80 with STOP_BITS=2: the second start bit begins on the cycle right after the last stop-bit cycle; no extra idle cycles between frames.
- Assert rst during the DATA bits of the first of 3 queued words: tx=1 immediately, fifo_count=0, busy=0; after release the line stays idle and nothing is transmitted.
- DATA_BITS=5, write 0x1F with upper input bits set to 1: only 5 data bits are sent, followed by stop; upper bits are ignored.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an integrated transmit FIFO.
// The frame is: one start bit, then DATA_BITS data bits sent LSB first,
// then an optional parity bit, then STOP_BITS stop bits.
// When the FIFO still holds a word at the end of the stop period, the next
// frame starts straight away with no idle cycle between frames.
module uart_tx_fifo_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 4;

    // Parity mode 3 and above behaves the same as mode 0 (no parity bit).
    localparam bit PARITY_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam bit PARITY_ODD = (PARITY_MODE == 2);

    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 baud_wrap;
    logic                 push;
    logic                 pop;

    assign baud_wrap = (baud_cnt == BAUD_MAX);
    // A write is accepted only when the registered full flag is low, even if a pop happens on the same edge.
    assign push      = wr_en && !full;
    // A word is popped from IDLE, or on the last cycle of the final stop bit.
    assign pop       = !empty && ((state == IDLE) ||
                                  (state == STOP && baud_wrap && bit_cnt == LAST_STOP));

    // Storage array written on every accepted push.
    // NOTE: the storage array has no reset. The pointers and the count decide what
    // is valid, so contents left from before a reset are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Next occupancy: a push together with a pop leaves the count unchanged.
    always_comb begin
        // NOTE: every path assigns count_next because of this default, so no latch is inferred.
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + CNT_W'(1);
            2'b01:   count_next = fifo_count - CNT_W'(1);
            default: count_next = fifo_count;
        endcase
    end

    // Pointer, count and status flag registers.
    // NOTE: sequential state is assigned with <= only. Every register then samples
    // the values from before the edge, so the order of statements does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            full       <= (count_next == FULL_CNT);
            empty      <= (count_next == '0);
            // A rejected write sets the flag; setting it takes priority over clearing it.
            if (wr_en && full)      overflow <= 1'b1;
            else if (clr_overflow)  overflow <= 1'b0;
        end
    end

    // Framing state machine. tx and busy are driven from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (pop) begin
                state      <= START;
                tx         <= 1'b0;
                busy       <= 1'b1;
                baud_cnt   <= '0;
                bit_cnt    <= '0;
                shift_reg  <= mem[rd_ptr];
                parity_bit <= (^mem[rd_ptr]) ^ PARITY_ODD;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                            tx       <= shift_reg[0];
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                if (PARITY_EN) begin
                                    state <= PARITY;
                                    tx    <= parity_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt   <= bit_cnt + BIT_W'(1);
                                shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                                tx        <= shift_reg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    PARITY: begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    STOP: begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt <= '0;
                                state   <= IDLE;
                                busy    <= 1'b0;
                                tx      <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Testbench for uart_tx_fifo_param. It runs five instances, each with a
// different parameter set. A small line model lists the expected tx and busy
// value for every cycle and queues them. A monitor then compares that queue
// with the DUT one sample per cycle, on the falling clock edge.
module tb_uart_tx_fifo_param;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int N     = 5;

    // Per-instance parameter sets:
    //   0: 8-N-1   1: 8-E-1   2: 8-O-1   3: 8-N-2   4: 5-N-1
    function automatic int db_of(int k);
        return (k == 4) ? 5 : 8;
    endfunction
    function automatic int pm_of(int k);
        case (k)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int sb_of(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    logic       clk;
    logic       rst;
    logic       wr_en    [N];
    logic [7:0] wr_data  [N];
    logic       clr_ov   [N];
    logic       tx_o     [N];
    logic       busy_o   [N];
    logic       full_o   [N];
    logic       empty_o  [N];
    logic       ovf_o    [N];
    logic [2:0] cnt_o    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DB = db_of(g);
        uart_tx_fifo_param #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_MODE  (pm_of(g)),
            .STOP_BITS    (sb_of(g)),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[g]),
            .wr_data      (wr_data[g][DB-1:0]),
            .clr_overflow (clr_ov[g]),
            .tx           (tx_o[g]),
            .busy         (busy_o[g]),
            .full         (full_o[g]),
            .empty        (empty_o[g]),
            .fifo_count   (cnt_o[g]),
            .overflow     (ovf_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
    } samp_t;

    samp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue n idle-line samples: tx high, busy low.
    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{tx: 1'b1, busy: 1'b0});
    endtask

    // Queue the waveform of one complete frame for instance k.
    task automatic push_frame(int k, logic [7:0] w);
        logic b_q[$];
        logic par;
        par = 1'b0;
        b_q.push_back(1'b0);
        for (int i = 0; i < db_of(k); i++) begin
            b_q.push_back(w[i]);
            par = par ^ w[i];
        end
        if (pm_of(k) == 1) b_q.push_back(par);
        if (pm_of(k) == 2) b_q.push_back(~par);
        for (int i = 0; i < sb_of(k); i++) b_q.push_back(1'b1);
        foreach (b_q[i])
            for (int c = 0; c < CPB; c++) exp_q.push_back('{tx: b_q[i], busy: 1'b1});
    endtask

    // Present one word at a falling edge; it is sampled on the next rising edge.
    task automatic send(int k, logic [7:0] w);
        wr_en[k]   = 1'b1;
        wr_data[k] = w;
        @(negedge clk);
        wr_en[k]   = 1'b0;
    endtask

    // Pop the queue and compare tx and busy of instance k once per cycle.
    task automatic watch(int k, int n);
        samp_t s;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s = exp_q.pop_front();
            check($sformatf("tx[%0d] cyc %0d", k, i), tx_o[k], s.tx);
            check($sformatf("busy[%0d] cyc %0d", k, i), busy_o[k], s.busy);
        end
    endtask

    // Single-frame test: one idle cycle after the write edge, then the frame, then idle.
    task automatic single_frame(int k, logic [7:0] w);
        int n;
        exp_q.delete();
        push_idle(1);
        push_frame(k, w);
        push_idle(4);
        n = exp_q.size();
        fork
            send(k, w);
            watch(k, n);
        join
        check($sformatf("empty_after[%0d]", k), empty_o[k], 1'b1);
        check($sformatf("count_after[%0d]", k), cnt_o[k], 3'd0);
    endtask

    initial begin
        int n;
        logic [7:0] words [6];

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            wr_en[k] = 1'b0; wr_data[k] = 8'h00; clr_ov[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_tx[%0d]", k), tx_o[k], 1'b1);
            check($sformatf("rst_busy[%0d]", k), busy_o[k], 1'b0);
            check($sformatf("rst_empty[%0d]", k), empty_o[k], 1'b1);
            check($sformatf("rst_full[%0d]", k), full_o[k], 1'b0);
            check($sformatf("rst_count[%0d]", k), cnt_o[k], 3'd0);
            check($sformatf("rst_ovf[%0d]", k), ovf_o[k], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 8-N-1 reference frame, even and odd parity, 5 data bits with the upper input bits set.
        single_frame(0, 8'hA5);
        single_frame(1, 8'h07);
        single_frame(2, 8'h07);
        single_frame(4, 8'hFF);

        // Back-to-back frames with two stop bits.
        exp_q.delete();
        push_idle(1);
        push_frame(3, 8'h01);
        push_frame(3, 8'h80);
        push_idle(4);
        n = exp_q.size();
        fork
            begin
                send(3, 8'h01);
                send(3, 8'h80);
            end
            watch(3, n);
        join
        check("b2b_empty", empty_o[3], 1'b1);

        // Overflow: six writes on consecutive edges into a 4-deep FIFO.
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.delete();
        push_idle(1);
        for (int i = 0; i < 5; i++) push_frame(0, words[i]);
        push_idle(4);
        n = exp_q.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, words[i]);
                check("ovf_count", cnt_o[0], 3'd4);
                check("ovf_full", full_o[0], 1'b1);
                check("ovf_flag", ovf_o[0], 1'b1);
                clr_ov[0] = 1'b1;
                @(negedge clk);
                clr_ov[0] = 1'b0;
                check("ovf_cleared", ovf_o[0], 1'b0);
                check("ovf_full_kept", full_o[0], 1'b1);
            end
            watch(0, n);
        join
        check("ovf_drained", empty_o[0], 1'b1);

        // Reset during the data bits of the first of three queued words.
        for (int i = 0; i < 3; i++) send(0, 8'h3C + 8'(i));
        repeat (6) @(negedge clk);
        check("mid_busy", busy_o[0], 1'b1);
        check("mid_count", cnt_o[0], 3'd2);
        #1 rst = 1'b1;
        #1;
        check("abort_tx", tx_o[0], 1'b1);
        check("abort_busy", busy_o[0], 1'b0);
        check("abort_count", cnt_o[0], 3'd0);
        check("abort_empty", empty_o[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_idle(60);
        watch(0, 60);
        check("post_rst_count", cnt_o[0], 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
